// File: rtl/avmm_mem_responder_pkg.sv
// Shared widths, parameter limits and the byte-merge helper for the
// Avalon-MM memory responder.
package avmm_mem_responder_pkg;

  localparam int DATA_W           = 32;
  localparam int BE_W             = DATA_W / 8;
  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 8;
  localparam int MAX_PENDING_MIN  = 1;
  localparam int MAX_PENDING_MAX  = 8;
  localparam int PEND_W           = $clog2(MAX_PENDING_MAX + 1);

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [BE_W-1:0]   be_t;

  function automatic word_t be_merge(input word_t old_w, input word_t new_w, input be_t be);
    word_t res;
    res = old_w;
    for (int b = 0; b < BE_W; b++) begin
      if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/resp_mem_array.sv
// Word-addressed storage with a byte-enabled write port and a registered
// read port that holds its value between reads.
module resp_mem_array
  import avmm_mem_responder_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  word_t             wr_data_i,
  input  be_t               wr_be_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output word_t             rd_data_o
);

  word_t mem [2**ADDR_W];
  word_t rd_data_q;

  // NOTE: the array has no reset branch so it maps onto block RAM; contents
  // survive rst_n and may be preloaded by the bench.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem[wr_addr_i] <= be_merge(mem[wr_addr_i], wr_data_i, wr_be_i);
  end

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/avmm_mem_responder.sv
// Avalon-MM slave backed by resp_mem_array: fixed read latency, bounded
// outstanding reads, optional periodic forced stalls, sticky protocol error.
module avmm_mem_responder
  import avmm_mem_responder_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int READ_LATENCY = 2,
  parameter int MAX_PENDING  = 4,
  parameter int STALL_PERIOD = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] slave_address,
  input  logic        slave_read,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic [3:0]  slave_byteenable,
  output logic        slave_waitrequest,
  output logic [31:0] slave_readdata,
  output logic        slave_readdatavalid,
  output logic        protocol_error
);

  logic [ADDR_W-1:0]       word_idx;
  logic                    unused_addr;
  logic                    run_q;
  logic                    stall_hit;
  logic                    rd_acc, wr_acc, cmd_conflict;
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [PEND_W-1:0]       pend_q, pend_d;
  logic                    perr_q, perr_d;
  word_t                   mem_rdata;

  assign word_idx    = slave_address[ADDR_W+1:2];
  assign unused_addr = ^{slave_address >> (ADDR_W + 2), slave_address[1:0]};

  assign slave_readdatavalid = vld_q[READ_LATENCY-1];
  assign protocol_error      = perr_q;
  assign slave_waitrequest   = !run_q || stall_hit ||
                               ((pend_q == PEND_W'(MAX_PENDING)) && !slave_readdatavalid);

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    rd_acc       = slave_read  && !slave_write && !slave_waitrequest;
    wr_acc       = slave_write && !slave_read  && !slave_waitrequest;
    cmd_conflict = slave_read  &&  slave_write && !slave_waitrequest;
    vld_d        = (vld_q << 1) | READ_LATENCY'(rd_acc);
    perr_d       = perr_q | cmd_conflict;
    pend_d       = pend_q;
    if (rd_acc && !slave_readdatavalid)      pend_d = pend_q + PEND_W'(1);
    else if (!rd_acc && slave_readdatavalid) pend_d = pend_q - PEND_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      vld_q  <= '0;
      pend_q <= '0;
      perr_q <= 1'b0;
    end else begin
      run_q  <= 1'b1;
      vld_q  <= vld_d;
      pend_q <= pend_d;
      perr_q <= perr_d;
    end
  end

  if (STALL_PERIOD > 0) begin : g_stall
    localparam int STALL_CW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
    logic [STALL_CW-1:0] stall_cnt_q;

    assign stall_hit = (stall_cnt_q == STALL_CW'(STALL_PERIOD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         stall_cnt_q <= '0;
      else if (stall_hit) stall_cnt_q <= '0;
      else                stall_cnt_q <= stall_cnt_q + STALL_CW'(1);
    end
  end else begin : g_no_stall
    assign stall_hit = 1'b0;
  end

  resp_mem_array #(.ADDR_W(ADDR_W)) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_acc),
    .wr_addr_i (word_idx),
    .wr_data_i (slave_writedata),
    .wr_be_i   (slave_byteenable),
    .rd_en_i   (rd_acc),
    .rd_addr_i (word_idx),
    .rd_data_o (mem_rdata)
  );

  // Stage 0 is the memory read register; data advances only behind a valid
  // bit, so the last stage holds the previous response while idle.
  if (READ_LATENCY == 1) begin : g_lat1
    assign slave_readdata = mem_rdata;
  end else begin : g_pipe
    word_t data_q [1:READ_LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 1; i < READ_LATENCY; i++) data_q[i] <= '0;
      end else begin
        if (vld_q[0]) data_q[1] <= mem_rdata;
        for (int i = 2; i < READ_LATENCY; i++) begin
          if (vld_q[i-1]) data_q[i] <= data_q[i-1];
        end
      end
    end

    assign slave_readdata = data_q[READ_LATENCY-1];
  end

endmodule
